// File: rtl/sound_sequencer.sv
// Event-driven tone sequencer: plays one fixed-length square-wave tone per collision event,
// followed by a silent gap, with a single-entry last-wins buffer for events that arrive meanwhile.
module sound_sequencer #(
    parameter int unsigned HALF_1    = 56818,
    parameter int unsigned HALF_2    = 37879,
    parameter int unsigned HALF_3    = 28409,
    parameter int unsigned HALF_4    = 113636,
    parameter int unsigned DUR_TICKS = 5000000,
    parameter int unsigned GAP_TICKS = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic [2:0] code,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic [2:0] cur_code
);

    localparam logic [23:0] H1_LAST  = 24'(HALF_1 - 1);
    localparam logic [23:0] H2_LAST  = 24'(HALF_2 - 1);
    localparam logic [23:0] H3_LAST  = 24'(HALF_3 - 1);
    localparam logic [23:0] H4_LAST  = 24'(HALF_4 - 1);
    localparam logic [23:0] DUR_LAST = 24'(DUR_TICKS - 1);
    localparam logic [23:0] GAP_LAST = 24'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] half_q, half_d;
    logic [23:0] dur_q, dur_d;
    logic [23:0] gap_q, gap_d;
    logic        phase_q, phase_d;
    logic        speaker_q, speaker_d;
    logic        busy_q, busy_d;
    logic [2:0]  cur_q, cur_d;
    logic [2:0]  pend_q, pend_d;
    logic        pendValid_q, pendValid_d;
    logic        evValid;
    logic [23:0] halfLast;

    assign evValid = trigger && (code >= 3'd1) && (code <= 3'd4);

    always_comb begin
        case (cur_q)
            3'd1:    halfLast = H1_LAST;
            3'd2:    halfLast = H2_LAST;
            3'd3:    halfLast = H3_LAST;
            3'd4:    halfLast = H4_LAST;
            default: halfLast = H1_LAST;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        dur_d       = dur_q;
        gap_d       = gap_q;
        phase_d     = phase_q;
        cur_d       = cur_q;
        pend_d      = pend_q;
        pendValid_d = pendValid_q;

        case (state_q)
            IDLE: begin
                if (evValid) begin
                    state_d = PLAY;
                    cur_d   = code;
                    half_d  = '0;
                    dur_d   = '0;
                    phase_d = 1'b0;
                end
            end

            PLAY: begin
                if (evValid) begin
                    pend_d      = code;
                    pendValid_d = 1'b1;
                end
                if (dur_q == DUR_LAST) begin
                    state_d = GAP;
                    gap_d   = '0;
                    cur_d   = 3'd0;
                    phase_d = 1'b0;
                end else begin
                    dur_d = dur_q + 24'd1;
                    if (half_q == halfLast) begin
                        half_d  = '0;
                        phase_d = ~phase_q;
                    end else begin
                        half_d = half_q + 24'd1;
                    end
                end
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    // A fresh event on the exit cycle beats the older buffered one.
                    if (evValid) begin
                        state_d     = PLAY;
                        cur_d       = code;
                        half_d      = '0;
                        dur_d       = '0;
                        phase_d     = 1'b0;
                        pendValid_d = 1'b0;
                    end else if (pendValid_q) begin
                        state_d     = PLAY;
                        cur_d       = pend_q;
                        half_d      = '0;
                        dur_d       = '0;
                        phase_d     = 1'b0;
                        pendValid_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 24'd1;
                    if (evValid) begin
                        pend_d      = code;
                        pendValid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Mute only gates the registered pin; the phase keeps running underneath.
    assign speaker_d = phase_d & ~mute;
    assign busy_d    = (state_d != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            half_q      <= '0;
            dur_q       <= '0;
            gap_q       <= '0;
            phase_q     <= 1'b0;
            speaker_q   <= 1'b0;
            busy_q      <= 1'b0;
            cur_q       <= 3'd0;
            pend_q      <= 3'd0;
            pendValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            dur_q       <= dur_d;
            gap_q       <= gap_d;
            phase_q     <= phase_d;
            speaker_q   <= speaker_d;
            busy_q      <= busy_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            pendValid_q <= pendValid_d;
        end
    end

    assign speaker  = speaker_q;
    assign busy     = busy_q;
    assign cur_code = cur_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: directed scenarios plus random events, all compared
// against a time-based behavioural model of tones, gaps and the one-entry event buffer.
module tb_sound_sequencer;

    localparam int H1 = 4, H2 = 6, H3 = 8, H4 = 16, DUR = 40, GAPT = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       trigger = 1'b0;
    logic [2:0] code = 3'd0;
    logic       mute = 1'b0;
    logic       speaker, busy;
    logic [2:0] cur_code;

    int checks = 0;
    int errors = 0;

    sound_sequencer #(
        .HALF_1(H1), .HALF_2(H2), .HALF_3(H3), .HALF_4(H4),
        .DUR_TICKS(DUR), .GAP_TICKS(GAPT)
    ) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .code(code), .mute(mute),
        .speaker(speaker), .busy(busy), .cur_code(cur_code)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 tone, 2 gap; waveform derived from time elapsed since tone start.
    int         mMode = 0, mStart = 0, mNow = 0, mCode = 0, mPend = 0;
    bit         mPendValid = 0;
    logic       mSpk = 1'b0, mBusy = 1'b0;
    logic [2:0] mCur = 3'd0;

    function automatic int halfOf(input int c);
        case (c)
            1: return H1;
            2: return H2;
            3: return H3;
            default: return H4;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mMode = 0; mStart = 0; mNow = 0; mCode = 0; mPend = 0; mPendValid = 0;
            mSpk = 1'b0; mBusy = 1'b0; mCur = 3'd0;
        end else begin
            bit evt;
            int e;
            evt = trigger && (code >= 3'd1) && (code <= 3'd4);
            e = mNow - mStart;
            mNow++;
            if (mMode == 0) begin
                if (evt) begin mMode = 1; mCode = int'(code); mStart = mNow; end
            end else if (mMode == 1) begin
                if (evt) begin mPend = int'(code); mPendValid = 1; end
                if (e == DUR - 1) begin mMode = 2; mStart = mNow; end
            end else begin
                if (e == GAPT - 1) begin
                    if (evt) begin
                        mMode = 1; mCode = int'(code); mStart = mNow; mPendValid = 0;
                    end else if (mPendValid) begin
                        mMode = 1; mCode = mPend; mStart = mNow; mPendValid = 0;
                    end else begin
                        mMode = 0;
                    end
                end else if (evt) begin
                    mPend = int'(code); mPendValid = 1;
                end
            end
            mBusy = (mMode != 0);
            mCur  = (mMode == 1) ? 3'(mCode) : 3'd0;
            mSpk  = (mMode == 1) && !mute && ((((mNow - mStart) / halfOf(mCode)) % 2) == 1);
        end
    end

    task automatic test_reset();
        trigger = 1'b1; code = 3'd1;
        repeat (3) @(negedge clk);
        checks++;
        if ({speaker, busy, cur_code} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: got spk=%b busy=%b cur=%0d want 0 0 0", speaker, busy, cur_code);
        end
        trigger = 1'b0; code = 3'd0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({speaker, busy, cur_code} !== 5'b0) begin
            errors++;
            $display("FAIL reset_release: got spk=%b busy=%b cur=%0d want 0 0 0", speaker, busy, cur_code);
        end
    endtask

    task automatic test_basic_tone();
        int rises = 0, busyCycles = 0;
        logic prevSpk = 1'b0;
        trigger = 1'b1; code = 3'd1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            checks++;
            if ({speaker, busy, cur_code} !== {mSpk, mBusy, mCur}) begin
                errors++;
                $display("FAIL basic_tone step %0d: got spk=%b busy=%b cur=%0d want spk=%b busy=%b cur=%0d",
                         i, speaker, busy, cur_code, mSpk, mBusy, mCur);
            end
            if (speaker && !prevSpk) rises++;
            prevSpk = speaker;
            if (busy) busyCycles++;
            if (i == 1) trigger = 1'b0;
        end
        checks++;
        if (rises !== 5) begin
            errors++; $display("FAIL basic_rises: got %0d want 5", rises);
        end
        checks++;
        if (busyCycles !== DUR + GAPT) begin
            errors++; $display("FAIL basic_busy_len: got %0d want %0d", busyCycles, DUR + GAPT);
        end
    endtask

    task automatic test_invalid_codes();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if ({speaker, busy, cur_code} !== 5'b0) begin
                errors++;
                $display("FAIL invalid_code step %0d: got spk=%b busy=%b cur=%0d want 0 0 0",
                         i, speaker, busy, cur_code);
            end
            trigger = (i == 0 || i == 3);
            code    = (i == 0) ? 3'd0 : 3'd6;
        end
        trigger = 1'b0;
    endtask

    task automatic test_pending_overwrite();
        int n4 = 0, n3 = 0, n2 = 0;
        trigger = 1'b1; code = 3'd4;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            checks++;
            if ({speaker, busy, cur_code} !== {mSpk, mBusy, mCur}) begin
                errors++;
                $display("FAIL overwrite step %0d: got spk=%b busy=%b cur=%0d want spk=%b busy=%b cur=%0d",
                         i, speaker, busy, cur_code, mSpk, mBusy, mCur);
            end
            if (cur_code == 3'd4) n4++;
            if (cur_code == 3'd3) n3++;
            if (cur_code == 3'd2) n2++;
            trigger = (i == 10 || i == 20);
            code    = (i == 10) ? 3'd2 : 3'd3;
        end
        trigger = 1'b0;
        checks++;
        if (n4 !== DUR) begin errors++; $display("FAIL overwrite_code4_len: got %0d want %0d", n4, DUR); end
        checks++;
        if (n3 !== DUR) begin errors++; $display("FAIL overwrite_code3_len: got %0d want %0d", n3, DUR); end
        checks++;
        if (n2 !== 0) begin errors++; $display("FAIL overwrite_code2_played: got %0d want 0", n2); end
    endtask

    task automatic test_back_to_back();
        int idleCycles = 0;
        trigger = 1'b1; code = 3'd1;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            checks++;
            if ({speaker, busy, cur_code} !== {mSpk, mBusy, mCur}) begin
                errors++;
                $display("FAIL back_to_back step %0d: got spk=%b busy=%b cur=%0d want spk=%b busy=%b cur=%0d",
                         i, speaker, busy, cur_code, mSpk, mBusy, mCur);
            end
            if (i <= 2 * DUR + GAPT && !busy) idleCycles++;
            if (i == DUR + GAPT + 1) begin
                checks++;
                if (cur_code !== 3'd2) begin
                    errors++; $display("FAIL gap_exit_code: got %0d want 2", cur_code);
                end
            end
            trigger = (i == DUR + GAPT);
            code    = 3'd2;
        end
        trigger = 1'b0;
        checks++;
        if (idleCycles !== 0) begin
            errors++; $display("FAIL back_to_back_idle: got %0d want 0", idleCycles);
        end
    endtask

    task automatic test_mute();
        mute = 1'b1; trigger = 1'b1; code = 3'd3;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            checks++;
            if ({speaker, busy, cur_code} !== {mSpk, mBusy, mCur}) begin
                errors++;
                $display("FAIL mute step %0d: got spk=%b busy=%b cur=%0d want spk=%b busy=%b cur=%0d",
                         i, speaker, busy, cur_code, mSpk, mBusy, mCur);
            end
            if (i <= 20 && speaker !== 1'b0) begin
                errors++; $display("FAIL mute_silent step %0d: got %b want 0", i, speaker);
            end
            if (i == 5 && cur_code !== 3'd3) begin
                errors++; $display("FAIL mute_cur_code: got %0d want 3", cur_code);
            end
            if (i == 25) begin
                checks++;
                if (speaker !== 1'b1) begin
                    errors++; $display("FAIL mute_resume_phase: got %b want 1", speaker);
                end
            end
            if (i == 1) trigger = 1'b0;
            if (i == 20) mute = 1'b0;
        end
    endtask

    task automatic test_reset_mid_tone();
        int seen1 = 0;
        trigger = 1'b1; code = 3'd2;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            checks++;
            if ({speaker, busy, cur_code} !== {mSpk, mBusy, mCur}) begin
                errors++;
                $display("FAIL reset_mid step %0d: got spk=%b busy=%b cur=%0d want spk=%b busy=%b cur=%0d",
                         i, speaker, busy, cur_code, mSpk, mBusy, mCur);
            end
            trigger = (i == 5);
            code    = 3'd1;
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({speaker, busy, cur_code} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got spk=%b busy=%b cur=%0d want 0 0 0", speaker, busy, cur_code);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || busy !== mBusy) begin
                errors++; $display("FAIL reset_mid_idle step %0d: got busy=%b want 0", i, busy);
            end
            if (cur_code == 3'd1) seen1++;
        end
        checks++;
        if (seen1 !== 0) begin
            errors++; $display("FAIL reset_pending_dropped: got %0d want 0", seen1);
        end
    endtask

    task automatic test_random();
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            checks++;
            if ({speaker, busy, cur_code} !== {mSpk, mBusy, mCur}) begin
                errors++;
                $display("FAIL random step %0d: got spk=%b busy=%b cur=%0d want spk=%b busy=%b cur=%0d",
                         i, speaker, busy, cur_code, mSpk, mBusy, mCur);
            end
            trigger = ($urandom_range(0, 11) == 0);
            code    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) mute = ~mute;
        end
        trigger = 1'b0; mute = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_tone();
        test_invalid_codes();
        test_pending_overwrite();
        test_back_to_back();
        repeat (60) @(negedge clk);
        test_mute();
        test_reset_mid_tone();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
Downstream consumer of the ball/collision stage's event outputs: wall, brick-hit and paddle/floor events. Turns each event into a fixed-length square-wave tone on a single speaker pin. Plays one tone at a time. Buffers one pending event so rapid collisions are neither chopped nor lost wholesale. Runs on the 50 MHz system clock; upstream glue delivers each event as a one-cycle trigger pulse with its 3-bit code.

Parameters:
HALF_1, 56818, half-period in clk cycles for code 1 (440 Hz, wall / brick hit 1)
HALF_2, 37879, half-period for code 2 (660 Hz, brick hit 2)
HALF_3, 28409, half-period for code 3 (880 Hz, brick destroyed)
HALF_4, 113636, half-period for code 4 (220 Hz, paddle / floor)
DUR_TICKS, 5000000, tone length in clk cycles (100 ms)
GAP_TICKS, 500000, silent gap after every tone (10 ms)
All values must be 1..2^24-1.

Ports:
clk  input  1  50 MHz system clock
reset  input  1  asynchronous, active-low reset
trigger  input  1  one-cycle event strobe, synchronous to clk
code  input  3  event code, sampled only when trigger=1
mute  input  1  forces speaker low; sequencing continues
speaker  output  1  square-wave drive to buzzer
busy  output  1  high in PLAY or GAP
cur_code  output  3  code currently playing, 0 when not in PLAY

Behaviour:
- Reset (reset=0, async): state=IDLE, speaker=0, busy=0, cur_code=0, pending_valid=0, pending_code=0, all counters=0.
- Valid event: trigger=1 and code in 1..4. Codes 0, 5, 6, 7 are ignored entirely.
- FSM states: IDLE, PLAY, GAP. All outputs are registered.
- IDLE:
  - Valid event at edge n → PLAY after edge n.
  - At that point: cur_code=code, half-period counter=0, duration counter=0, speaker=0, busy=1.
- PLAY:
  - Half counter increments every cycle.
  - When it equals HALF_k-1 (k=cur_code): speaker toggles and the counter clears. First rising edge of speaker is HALF_k cycles after entering PLAY.
  - Duration counter increments every cycle.
  - When it equals DUR_TICKS-1: → GAP. Speaker=0, cur_code=0, gap counter=0.
  - A valid event during PLAY stores code into pending (pending_valid=1). A later event overwrites it (last wins). The current tone is never interrupted.
- GAP:
  - Gap counter increments every cycle; speaker=0; busy=1.
  - When it equals GAP_TICKS-1:
    - If pending_valid: → PLAY with cur_code=pending_code, all PLAY counters reset, pending_valid cleared.
    - Else: → IDLE, busy=0.
  - A valid event during GAP is written to pending (overwrite).
- Same-cycle event and GAP exit: the incoming event takes precedence over the stored pending code. It starts PLAY immediately and pending_valid clears.
- Same-cycle event and PLAY→GAP transition: the event is written to pending.
- mute=1 gates speaker to 0 combinationally before the output register. State, counters and busy are unaffected. Deasserting mute mid-tone resumes at the current waveform phase.
- Counters are 24-bit unsigned; compare for equality, so no wrap-around is possible with legal parameters.
- Reset asserted mid-tone: immediate silence. Pending is discarded.

Test Plan:
Use overrides HALF_1=4, HALF_2=6, HALF_3=8, HALF_4=16, DUR_TICKS=40, GAP_TICKS=10.
1. Reset, then trigger code=1 → busy=1 next cycle. Speaker rises 4 cycles later and toggles every 4 cycles (5 rising edges). Speaker=0 and cur_code=0 after 40 PLAY cycles. busy=0 after 10 more cycles.
2. Trigger code=0, then code=6 → no state change; busy and speaker stay 0.
3. Trigger code=4; at PLAY cycle 10 trigger code=2; at cycle 20 trigger code=3 → full 40-cycle code-4 tone (half-period 16), 10-cycle gap, then a code-3 tone (half-period 8). Code 2 is never played.
4. Trigger code=1; trigger code=2 exactly on the last GAP cycle with no pending → PLAY code 2 starts the next cycle with no IDLE cycle.
5. Hold mute=1 through a code-3 tone → speaker constant 0 while busy and cur_code=3 behave as in scenario 1. Release mute at PLAY cycle 20 → speaker resumes with the phase it would have had unmuted.
6. Trigger code=2; pulse reset low at PLAY cycle 15 with a code-1 event pending → speaker=0, busy=0, cur_code=0 immediately. The code-1 event is not played after reset releases.
